// File: rtl/adau_i2s_tx.sv
// Stereo sample FIFO feeding an I2S serialiser (64 bclk per frame, 32-bit slots, MSB first).
// Optional macro ADAU_I2S_TX_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow counter output.
module adau_i2s_tx #(
   parameter int unsigned CLK_DIV = 16,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [23:0]        audio_l,
   input  logic [23:0]        audio_r,
   input  logic               audio_valid,
   output logic               audio_full,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               underflow,
   output logic               i2s_bclk,
   output logic               i2s_lrclk,
   output logic               i2s_sdata
`ifdef ADAU_I2S_TX_UNDERFLOW_CNT_EN
   ,
   output logic [15:0]        underflow_count
`endif
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned LW    = FIFO_AW + 1;
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [47:0]          r_mem [DEPTH];
   logic [FIFO_AW-1:0]   r_wr_ptr;
   logic [FIFO_AW-1:0]   r_rd_ptr;
   logic [FIFO_AW:0]     r_level;
   logic [47:0]          w_rd_data;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_wr;
   logic                 w_pop_req;
   logic                 w_pop;

   logic [DIV_W-1:0]     r_div;
   logic                 r_bclk;
   logic [5:0]           r_bit;
   logic                 r_lrclk;
   logic                 r_sdata;
   logic [23:0]          r_l;
   logic [23:0]          r_r;
   logic                 r_underflow;
   logic                 w_tick;
   logic                 w_frame_end;
   logic [5:0]           w_k;
   logic [4:0]           w_l_idx;
   logic [4:0]           w_r_idx;
   logic                 w_sdata_nxt;

   // ---------------- FIFO ----------------
   assign w_full    = (r_level == LW'(DEPTH));
   assign w_empty   = (r_level == '0);
   assign w_wr      = audio_valid & ~w_full;
   assign w_pop     = w_pop_req & ~w_empty;
   assign w_rd_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {audio_l, audio_r};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // ---------------- Serialiser control ----------------
   assign w_tick      = (r_state == ST_RUN) && (r_div == DIV_W'(CLK_DIV - 1));
   assign w_frame_end = w_tick && r_bclk && (r_bit == 6'd63);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop_req   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_state_nxt = ST_RUN;
               w_pop_req   = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_frame_end) begin
               if (enable) w_pop_req   = 1'b1;
               else        w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Next bit index and its data; k=0 yields lrclk=0/sdata=0, so the 63->0 wrap needs no special case.
   assign w_k = r_bit + 6'd1;

   always_comb begin
      w_sdata_nxt = 1'b0;
      w_l_idx     = 5'(6'd24 - w_k);
      w_r_idx     = 5'(6'd56 - w_k);
      if ((w_k >= 6'd1) && (w_k <= 6'd24))
         w_sdata_nxt = r_l[w_l_idx];
      else if ((w_k >= 6'd33) && (w_k <= 6'd56))
         w_sdata_nxt = r_r[w_r_idx];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div       <= '0;
         r_bclk      <= 1'b0;
         r_bit       <= '0;
         r_lrclk     <= 1'b0;
         r_sdata     <= 1'b0;
         r_l         <= '0;
         r_r         <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= w_pop_req & w_empty;
         if (w_pop_req) begin
            r_l <= w_empty ? '0 : w_rd_data[47:24];
            r_r <= w_empty ? '0 : w_rd_data[23:0];
         end
         if (r_state == ST_RUN) begin
            if (w_tick) begin
               r_div  <= '0;
               r_bclk <= ~r_bclk;
               if (r_bclk) begin
                  r_bit   <= w_k;
                  r_lrclk <= w_k[5];
                  r_sdata <= w_sdata_nxt;
               end
            end else begin
               r_div <= r_div + 1'b1;
            end
         end else begin
            r_div   <= '0;
            r_bclk  <= 1'b0;
            r_bit   <= '0;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
         end
      end
   end

`ifdef ADAU_I2S_TX_UNDERFLOW_CNT_EN
   logic [15:0] r_uf_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                           r_uf_cnt <= '0;
      else if (r_underflow && (r_uf_cnt != '1)) r_uf_cnt <= r_uf_cnt + 1'b1;
   end

   assign underflow_count = r_uf_cnt;
`endif

   assign audio_full = w_full;
   assign fifo_level = r_level;
   assign underflow  = r_underflow;
   assign i2s_bclk   = r_bclk;
   assign i2s_lrclk  = r_lrclk;
   assign i2s_sdata  = r_sdata;

endmodule

// File: tb/tb_adau_i2s_tx.sv
// Self-checking bench for adau_i2s_tx: table-driven FIFO fill plus an I2S receiver/scoreboard.
module tb_adau_i2s_tx;

   localparam int unsigned CLK_DIV = 2;
   localparam int unsigned FIFO_AW = 2;
   localparam int FRAME_CLK = 128 * CLK_DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [23:0] audio_l = '0;
   logic [23:0] audio_r = '0;
   logic        audio_valid = 1'b0;
   logic        audio_full;
   logic [FIFO_AW:0] fifo_level;
   logic        underflow;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
`ifdef ADAU_I2S_TX_UNDERFLOW_CNT_EN
   logic [15:0] underflow_count;
`endif

   adau_i2s_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .audio_l(audio_l), .audio_r(audio_r), .audio_valid(audio_valid),
      .audio_full(audio_full), .fifo_level(fifo_level), .underflow(underflow),
      .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata)
`ifdef ADAU_I2S_TX_UNDERFLOW_CNT_EN
      , .underflow_count(underflow_count)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [47:0] sb[$];
   int          uf_times[$];
   int          uf_cnt   = 0;
   int          n_frames = 0;
   int          mon_k    = 0;
   int          clk_cnt  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // I2S frame as seen on the wire: one idle bit, 24 bits MSB first, padding; same for the right slot.
   function automatic logic [63:0] exp_frame(input logic [47:0] pair);
      logic [63:0] f;
      logic [23:0] l;
      logic [23:0] r;
      f = '0;
      l = pair[47:24];
      r = pair[23:0];
      for (int i = 0; i < 24; i++) begin
         f[1 + i]  = l[23 - i];
         f[33 + i] = r[23 - i];
      end
      return f;
   endfunction

   // Receiver: samples sdata/lrclk on each bclk rise, compares whole frames against the scoreboard.
   initial begin
      logic        prev_bclk;
      logic [63:0] got_sd;
      logic [63:0] got_lr;
      logic [47:0] cur;
      int          t_k0;
      prev_bclk = 1'b0;
      got_sd = '0;
      got_lr = '0;
      cur = '0;
      t_k0 = 0;
      forever begin
         @(negedge clk);
         clk_cnt++;
         if (!reset) begin
            mon_k = 0;
            prev_bclk = 1'b0;
         end else begin
            if (underflow) begin
               uf_cnt++;
               uf_times.push_back(clk_cnt);
            end
            if (i2s_bclk && !prev_bclk) begin
               if (mon_k == 0) begin
                  cur  = (sb.size() > 0) ? sb.pop_front() : 48'h0;
                  t_k0 = clk_cnt;
               end
               got_sd[mon_k] = i2s_sdata;
               got_lr[mon_k] = i2s_lrclk;
               if (mon_k == 63) begin
                  check("frame_sdata", got_sd, exp_frame(cur));
                  check("frame_lrclk", got_lr, {32'hFFFF_FFFF, 32'h0});
                  check("frame_bits_len", 64'(clk_cnt - t_k0), 64'(63 * 2 * CLK_DIV));
                  n_frames++;
               end
               mon_k = (mon_k + 1) % 64;
            end
            prev_bclk = i2s_bclk;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frames(input int target, input string nm);
      for (int i = 0; i < 3000 && n_frames < target; i++) step();
      if (n_frames < target) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: timeout, frames=%0d, required %0d", nm, n_frames, target);
      end
   endtask

   task automatic wait_bit(input int k, input string nm);
      for (int i = 0; i < 1000 && mon_k != k; i++) step();
      if (mon_k != k) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: timeout, bit=%0d, required %0d", nm, mon_k, k);
      end
   endtask

   typedef struct {
      logic [23:0]      l;
      logic [23:0]      r;
      logic [FIFO_AW:0] exp_level;
      logic             exp_full;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic quiet;
      vecs[0] = '{24'hA5_0001, 24'h80_0000, 3'd1, 1'b0};
      vecs[1] = '{24'h12_3456, 24'hFE_DCBA, 3'd2, 1'b0};
      vecs[2] = '{24'h7F_FFFF, 24'h00_0001, 3'd3, 1'b0};
      vecs[3] = '{24'h00_0000, 24'hFF_FFFF, 3'd4, 1'b1};

      // Reset state
      #12;
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_full",  64'(audio_full), 64'd0);
      check("rst_outs",  64'({underflow, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'd0);
      step();
      reset = 1'b1;
      step();

      // Fill FIFO while idle
      for (int i = 0; i < 4; i++) begin
         audio_l = vecs[i].l;
         audio_r = vecs[i].r;
         audio_valid = 1'b1;
         step();
         check($sformatf("fill_level_%0d", i), 64'(fifo_level), 64'(vecs[i].exp_level));
         check($sformatf("fill_full_%0d", i),  64'(audio_full), 64'(vecs[i].exp_full));
         sb.push_back({vecs[i].l, vecs[i].r});
      end
      audio_l = 24'h5A_5A5A;
      audio_r = 24'h0F_0F0F;
      repeat (5) step();
      check("hold_level", 64'(fifo_level), 64'd4);
      check("hold_full",  64'(audio_full), 64'd1);

      // Start: pop in the cycle the held write is rejected, write lands one cycle later
      enable = 1'b1;
      step();
      check("pop_cycle_level", 64'(fifo_level), 64'd3);
      check("pop_cycle_full",  64'(audio_full), 64'd0);
      step();
      check("after_pop_level", 64'(fifo_level), 64'd4);
      check("after_pop_full",  64'(audio_full), 64'd1);
      sb.push_back({24'h5A_5A5A, 24'h0F_0F0F});
      audio_valid = 1'b0;

      // Stop request at bit 10 of the third frame
      wait_frames(2, "wait_ab");
      wait_bit(11, "wait_c_bit10");
      check("level_before_stop", 64'(fifo_level), 64'(sb.size()));
      enable = 1'b0;
      wait_frames(3, "wait_c_end");
      repeat (4) step();
      quiet = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (i2s_bclk || i2s_lrclk || i2s_sdata) quiet = 1'b1;
         step();
      end
      check("idle_quiet", 64'(quiet), 64'd0);
      check("level_after_stop", 64'(fifo_level), 64'd2);
      check("frames_after_stop", 64'(n_frames), 64'd3);

      // Resume, drain into an underflow frame, then stop again
      enable = 1'b1;
      wait_frames(5, "wait_de");
      wait_bit(11, "wait_z_bit10");
      check("uf_boundary", 64'(uf_cnt), 64'd1);
      enable = 1'b0;
      wait_frames(6, "wait_z_end");
      repeat (4) step();
      check("level_empty", 64'(fifo_level), 64'd0);

      // Start with an empty FIFO
      enable = 1'b1;
      step();
      check("uf_entry_pulse", 64'(underflow), 64'd1);
      step();
      check("uf_entry_one_clk", 64'(underflow), 64'd0);
      repeat (60) step();
      audio_l = 24'h3C_0FF0;
      audio_r = 24'h00_F00F;
      audio_valid = 1'b1;
      step();
      audio_valid = 1'b0;
      check("midframe_level", 64'(fifo_level), 64'd1);
      sb.push_back({24'h3C_0FF0, 24'h00_F00F});
      wait_frames(7, "wait_z2");
      wait_bit(33, "wait_f_bit32");
      check("uf_no_second", 64'(uf_cnt), 64'd2);

      // Asynchronous reset in the right slot while bclk is high
      audio_l = 24'h11_1111;
      audio_r = 24'h22_2222;
      audio_valid = 1'b1;
      step();
      step();
      audio_valid = 1'b0;
      check("pre_reset_level", 64'(fifo_level), 64'd2);
      for (int i = 0; i < 10 && !i2s_bclk; i++) step();
      check("pre_reset_bclk_lr", 64'({i2s_bclk, i2s_lrclk}), 64'd3);
      reset = 1'b0;
      enable = 1'b0;
      #1;
      check("async_rst_outs", 64'({underflow, i2s_bclk, i2s_lrclk, i2s_sdata}), 64'd0);
      check("async_rst_level", 64'(fifo_level), 64'd0);
      sb.delete();
      uf_times.delete();
      uf_cnt = 0;
      step();
      step();
      reset = 1'b1;
      step();

      // Three empty frames
      enable = 1'b1;
      for (int i = 0; i < 1000 && uf_cnt < 3; i++) step();
      check("uf_three", 64'(uf_cnt), 64'd3);
      if (uf_times.size() >= 3) begin
         check("uf_spacing_1", 64'(uf_times[1] - uf_times[0]), 64'(FRAME_CLK));
         check("uf_spacing_2", 64'(uf_times[2] - uf_times[1]), 64'(FRAME_CLK));
      end
`ifdef ADAU_I2S_TX_UNDERFLOW_CNT_EN
      step();
      check("uf_count_port", 64'(underflow_count), 64'd3);
`endif
      enable = 1'b0;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
